// File: rtl/gmii_rx_ptp_parser.sv
// gmii_rx_ptp_parser
//   Receive-side GMII frame parser. Finds preamble/SFD, samples rtc_time at
//   the SFD, recognises layer-2 PTP frames by EtherType, and extracts
//   messageType and sequenceId into one timestamp record per frame.
//   The record is offered downstream over a valid/ready handshake.
//
// Optional build macro: PTP_PARSER_VLAN_EN
//   When defined, one 802.1Q tag (0x8100) is skipped before the EtherType.
//
// Ports
//   gmii_rxclk   in   receive clock, all logic on its rising edge
//   rst          in   asynchronous reset, active-high
//   gmii_rxctrl  in   RX_DV
//   gmii_rxdata  in   receive byte
//   rtc_time     in   free-running RTC time, synchronous to gmii_rxclk
//   ptp_valid    out  record available
//   ptp_ready    in   downstream accepts record
//   ptp_ts       out  rtc_time sampled at the SFD
//   ptp_msgtype  out  PTP messageType
//   ptp_seqid    out  PTP sequenceId
//   drop_cnt     out  records lost to back-pressure, saturating
module gmii_rx_ptp_parser #(
    parameter int          TS_W        = 80,
    parameter logic [15:0] PTP_ETYPE   = 16'h88F7,
    parameter int          MIN_PTP_LEN = 34,
    parameter int          MAX_PRE     = 7
) (
    input  logic            gmii_rxclk,
    input  logic            rst,
    input  logic            gmii_rxctrl,
    input  logic [7:0]      gmii_rxdata,
    input  logic [TS_W-1:0] rtc_time,
    output logic            ptp_valid,
    input  logic            ptp_ready,
    output logic [TS_W-1:0] ptp_ts,
    output logic [3:0]      ptp_msgtype,
    output logic [15:0]     ptp_seqid,
    output logic [7:0]      drop_cnt
);
    localparam int PRE_W = $clog2(MAX_PRE + 2);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_armed;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [15:0]      r_byte_cnt;
    logic [15:0]      r_etype;
    logic [3:0]       r_msg_hold;
    logic [15:0]      r_seq_hold;
    logic [TS_W-1:0]  r_ts_hold;
    logic [15:0]      w_p;
    logic             w_pre_ovf;
    logic             w_is_ptp;
    logic             w_emit;

`ifdef PTP_PARSER_VLAN_EN
    logic             r_vlan;
    assign w_p = r_vlan ? 16'd18 : 16'd14;
`else
    assign w_p = 16'd14;
`endif

    assign w_pre_ovf = (int'(r_pre_cnt) + 1) > MAX_PRE;
    // A second 0x8100 tag leaves r_etype at 0x8100, so it is never PTP.
    assign w_is_ptp  = (r_etype == PTP_ETYPE);
    assign w_emit    = (r_state == S_DATA) && !gmii_rxctrl && w_is_ptp &&
                       (r_byte_cnt >= w_p + 16'(MIN_PTP_LEN));

    always_ff @(posedge gmii_rxclk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (gmii_rxctrl)
                        w_state_nxt = (gmii_rxdata == 8'h55 && r_armed) ? S_PRE : S_DROP;
            S_PRE: begin
                if (!gmii_rxctrl)               w_state_nxt = S_IDLE;
                else if (gmii_rxdata == 8'h55)  w_state_nxt = w_pre_ovf ? S_DROP : S_PRE;
                else if (gmii_rxdata == 8'hD5)  w_state_nxt = S_DATA;
                else                            w_state_nxt = S_DROP;
            end
            S_DATA:  if (!gmii_rxctrl) w_state_nxt = S_IDLE;
            default: if (!gmii_rxctrl) w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge gmii_rxclk or posedge rst) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_pre_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_etype     <= '0;
            r_msg_hold  <= '0;
            r_seq_hold  <= '0;
            r_ts_hold   <= '0;
`ifdef PTP_PARSER_VLAN_EN
            r_vlan      <= 1'b0;
`endif
            ptp_valid   <= 1'b0;
            ptp_ts      <= '0;
            ptp_msgtype <= '0;
            ptp_seqid   <= '0;
            drop_cnt    <= '0;
        end else begin
            // Only an observed idle gap allows a frame to start.
            if (!gmii_rxctrl) r_armed <= 1'b1;

            if (r_state == S_IDLE && gmii_rxctrl)
                r_pre_cnt <= PRE_W'(1);

            if (r_state == S_PRE && gmii_rxctrl) begin
                if (gmii_rxdata == 8'h55) r_pre_cnt <= r_pre_cnt + PRE_W'(1);
                if (gmii_rxdata == 8'hD5) begin
                    r_ts_hold  <= rtc_time;
                    r_byte_cnt <= '0;
                    r_etype    <= '0;
                    r_msg_hold <= '0;
                    r_seq_hold <= '0;
`ifdef PTP_PARSER_VLAN_EN
                    r_vlan     <= 1'b0;
`endif
                end
            end

            if (r_state == S_DATA && gmii_rxctrl) begin
                if (r_byte_cnt == 16'd12) r_etype[15:8] <= gmii_rxdata;
                if (r_byte_cnt == 16'd13) r_etype[7:0]  <= gmii_rxdata;
`ifdef PTP_PARSER_VLAN_EN
                if (r_byte_cnt == 16'd14 && r_etype == 16'h8100) r_vlan <= 1'b1;
                if (r_vlan && r_byte_cnt == 16'd16) r_etype[15:8] <= gmii_rxdata;
                if (r_vlan && r_byte_cnt == 16'd17) r_etype[7:0]  <= gmii_rxdata;
`endif
                // For a tagged frame byte 14 is captured here first, then
                // overwritten by byte 18 once the tag has been seen.
                if (r_byte_cnt == w_p)          r_msg_hold       <= gmii_rxdata[3:0];
                if (r_byte_cnt == w_p + 16'd30) r_seq_hold[15:8] <= gmii_rxdata;
                if (r_byte_cnt == w_p + 16'd31) r_seq_hold[7:0]  <= gmii_rxdata;
                if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
            end

            // A pending handshake on the load edge frees the slot for the new record.
            if (w_emit) begin
                if (ptp_valid && !ptp_ready) begin
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end else begin
                    ptp_valid   <= 1'b1;
                    ptp_ts      <= r_ts_hold;
                    ptp_msgtype <= r_msg_hold;
                    ptp_seqid   <= r_seq_hold;
                end
            end else if (ptp_valid && ptp_ready) begin
                ptp_valid <= 1'b0;
            end
        end
    end
endmodule
